// File: rtl/logic_pipe_pkg.sv
// rtl/logic_pipe_pkg.sv - op encodings, op width and default datapath width for logic_pipe_unit
package logic_pipe_pkg;

  localparam int OP_W          = 3;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NOR    = 3'b011,
    OP_ANDN   = 3'b100,
    OP_PASS_A = 3'b101,
    OP_RAND   = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

endpackage

// File: rtl/logic_pipe_stage.sv
// rtl/logic_pipe_stage.sv - one valid/ready register stage carrying result, illegal and optional zero flag
// Optional zero flag: LOGIC_PIPE_ZERO_FLAG_EN
module logic_pipe_stage import logic_pipe_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_illegal,
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  input  logic             in_zero,
  output logic             out_zero,
`endif
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_illegal,
  input  logic             out_ready
);

  logic load;

  // Loadable when empty or when the current contents leave this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_illegal <= 1'b0;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      out_zero    <= 1'b0;
`endif
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      // Data is left untouched by flush; only the valid bit is dropped.
      if (load) begin
        out_data    <= in_data;
        out_illegal <= in_illegal;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        out_zero    <= in_zero;
`endif
      end
    end
  end

endmodule

// File: rtl/logic_pipe_unit.sv
// rtl/logic_pipe_unit.sv - pipelined bitwise logic unit with ready/valid flow control
// Optional Zero output: LOGIC_PIPE_ZERO_FLAG_EN
module logic_pipe_unit import logic_pipe_pkg::*; #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  output logic             Zero,
`endif
  output logic             Illegal
);

  logic [WIDTH-1:0]  res_c;
  logic              ill_c;
  logic              rst_done;
  logic [STAGES-1:0] vq;
  logic [STAGES-1:0] il_q;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  d_q [STAGES];
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  logic              zero_c;
  logic [STAGES-1:0] zq;
`endif

  always_comb begin
    res_c = '0;
    ill_c = 1'b0;
    case (op_e'(Op))
      OP_AND:    res_c = A & B;
      OP_OR:     res_c = A | B;
      OP_XOR:    res_c = A ^ B;
      OP_NOR:    res_c = ~(A | B);
      OP_ANDN:   res_c = A & ~B;
      OP_PASS_A: res_c = A;
      OP_RAND:   res_c[0] = &A;
      default:   ill_c = 1'b1;
    endcase
  end

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  assign zero_c = ~|res_c;
`endif

  // Holds input off for the first cycle after reset so InReady rises one cycle after release.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  assign InReady = rst_done & ~Reset & ~Flush & rdy[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             vin;
    logic             iin;
    logic [WIDTH-1:0] din;
    logic             dn_ready;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    logic             zin;
`endif

    if (i == 0) begin : g_first
      assign vin = InValid & InReady;
      assign din = res_c;
      assign iin = ill_c;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      assign zin = zero_c;
`endif
    end else begin : g_next
      assign vin = vq[i-1] & rdy[i];
      assign din = d_q[i-1];
      assign iin = il_q[i-1];
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      assign zin = zq[i-1];
`endif
    end

    // Downstream readiness comes straight from the valid bits so the ready path never loops back on itself.
    if (i == STAGES - 1) begin : g_last
      assign dn_ready = OutReady;
    end else begin : g_mid
      assign dn_ready = OutReady | ~&vq[STAGES-1:i+1];
    end

    logic_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk         (Clk),
      .reset       (Reset),
      .flush       (Flush),
      .in_valid    (vin),
      .in_data     (din),
      .in_illegal  (iin),
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      .in_zero     (zin),
      .out_zero    (zq[i]),
`endif
      .in_ready    (rdy[i]),
      .out_valid   (vq[i]),
      .out_data    (d_q[i]),
      .out_illegal (il_q[i]),
      .out_ready   (dn_ready)
    );
  end

  assign OutValid = vq[STAGES-1];
  assign Result   = d_q[STAGES-1];
  assign Illegal  = il_q[STAGES-1];
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  assign Zero     = zq[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_pipe_unit.sv
// tb/tb_logic_pipe_unit.sv - directed self-checking bench for logic_pipe_unit (WIDTH=32, STAGES=2)
module tb_logic_pipe_unit;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, OutReady;
  logic [31:0] A, B;
  logic [2:0]  Op;
  logic        InReady, OutValid, Illegal;
  logic [31:0] Result;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  logic        Zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  logic_pipe_unit #(.WIDTH(32), .STAGES(2)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .Op       (Op),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    .Zero     (Zero),
`endif
    .Illegal  (Illegal)
  );

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    A = '0; B = '0; Op = 3'b000;
    cyc(); cyc();
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %0b want 0", OutValid); end
    checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", Result); end
    checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b want 0", Illegal); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL reset_inready got %0b want 0", InReady); end
    Reset = 1'b0;
    cyc();
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_release_inready got %0b want 1", InReady); end
  endtask

  task automatic test_ops();
    logic [2:0]  t_op  [9] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b110, 3'b110};
    logic [31:0] t_a   [9] = '{32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF,
                               32'hF0F000FF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] t_b   [9] = '{32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F,
                               32'h0FF00F0F, 32'h9ABCDEF0, 32'h00000000, 32'h00000000};
    logic [31:0] t_exp [9] = '{32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0, 32'h000FF000, 32'hF00000F0,
                               32'hF0F000FF, 32'h00000000, 32'h00000001, 32'h00000000};
    logic        t_ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    OutReady = 1'b1;
    for (int t = 0; t < 11; t++) begin
      if (t < 9) begin
        InValid = 1'b1; Op = t_op[t]; A = t_a[t]; B = t_b[t];
      end else begin
        InValid = 1'b0;
      end
      #1;
      if (t < 9) begin
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL ops_inready[%0d] got %0b want 1", t, InReady); end
      end
      if (t < 2) begin
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL ops_early_valid[%0d] got %0b want 0", t, OutValid); end
      end else begin
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL ops_valid[%0d] got %0b want 1", t - 2, OutValid); end
        checks++; if (Result !== t_exp[t-2]) begin errors++; $display("FAIL ops_result[%0d] got %h want %h", t - 2, Result, t_exp[t-2]); end
        checks++; if (Illegal !== t_ill[t-2]) begin errors++; $display("FAIL ops_illegal[%0d] got %0b want %0b", t - 2, Illegal, t_ill[t-2]); end
      end
      cyc();
    end
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL ops_drain got %0b want 0", OutValid); end
  endtask

  task automatic test_stall();
    logic [31:0] v [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    OutReady = 1'b0; InValid = 1'b1; Op = 3'b101; B = '0;
    A = v[0];
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL stall_accept0 got %0b want 1", InReady); end
    cyc();
    A = v[1];
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL stall_accept1 got %0b want 1", InReady); end
    cyc();
    A = v[2];
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL stall_inready[%0d] got %0b want 0", k, InReady); end
      checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b want 1", k, OutValid); end
      checks++; if (Result !== v[0]) begin errors++; $display("FAIL stall_result[%0d] got %h want %h", k, Result, v[0]); end
      cyc();
    end
    OutReady = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL stall_full_accept got %0b want 1", InReady); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) #1;
      checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL stall_drain_valid[%0d] got %0b want 1", k, OutValid); end
      checks++; if (Result !== v[k]) begin errors++; $display("FAIL stall_drain_result[%0d] got %h want %h", k, Result, v[k]); end
      cyc();
      InValid = 1'b0;
    end
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got %0b want 0", OutValid); end
  endtask

  task automatic test_flush();
    OutReady = 1'b0; InValid = 1'b1; Op = 3'b101; B = '0;
    A = 32'hDEAD0001;
    cyc();
    A = 32'hDEAD0002;
    cyc();
    A = 32'hDEAD0003; Flush = 1'b1;
    #1;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL flush_inready got %0b want 0", InReady); end
    cyc();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", OutValid); end
    checks++; if (Result !== 32'hDEAD0001) begin errors++; $display("FAIL flush_data_kept got %h want dead0001", Result); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got %0b want 0", k, OutValid); end
    end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL flush_recover got %0b want 1", InReady); end
  endtask

  task automatic test_reset_mid();
    OutReady = 1'b1; InValid = 1'b1; B = '0;
    Op = 3'b101; A = 32'hCAFEF00D;
    cyc();
    Op = 3'b111; A = 32'h0BADBEEF;
    cyc();
    Op = 3'b101; A = 32'h5A5A5A5A; Reset = 1'b1;
    cyc();
    Reset = 1'b0; InValid = 1'b0;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", OutValid); end
    checks++; if (Result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 00000000", Result); end
    checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL rstmid_illegal got %0b want 0", Illegal); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rstmid_inready got %0b want 0", InReady); end
    cyc();
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rstmid_release got %0b want 1", InReady); end
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rstmid_leak0 got %0b want 0", OutValid); end
    cyc();
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rstmid_leak1 got %0b want 0", OutValid); end
  endtask

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  task automatic test_zero();
    logic [2:0] z_op  [2] = '{3'b000, 3'b001};
    logic       z_exp [2] = '{1'b1, 1'b0};
    OutReady = 1'b1; A = 32'hAAAAAAAA; B = 32'h55555555;
    for (int t = 0; t < 4; t++) begin
      if (t < 2) begin
        InValid = 1'b1; Op = z_op[t];
      end else begin
        InValid = 1'b0;
      end
      #1;
      if (t >= 2) begin
        checks++; if (Zero !== z_exp[t-2]) begin errors++; $display("FAIL zero_flag[%0d] got %0b want %0b", t - 2, Zero, z_exp[t-2]); end
      end
      cyc();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_stall();
    test_flush();
    test_reset_mid();
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    test_zero();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_pipe_unit.md
LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 2, number of register stages from input to output (legal 1..4).
REQ-003 SHALL have port Clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Flush  input  1  synchronous discard of all in-flight operations.
REQ-006 SHALL have port InValid  input  1  operands and op are presented this cycle.
REQ-007 SHALL have port InReady  output  1  unit accepts input this cycle.
REQ-008 SHALL have port A  input  WIDTH  first operand.
REQ-009 SHALL have port B  input  WIDTH  second operand.
REQ-010 SHALL have port Op  input  3  operation select.
REQ-011 SHALL have port OutValid  output  1  Result is valid.
REQ-012 SHALL have port OutReady  input  1  downstream accepts Result.
REQ-013 SHALL have port Result  output  WIDTH  operation result.
REQ-014 SHALL have port Illegal  output  1  the result came from a reserved Op.

Function
REQ-015 SHALL decode Op as follows: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ANDN (A & ~B), 101 PASS_A, 110 RAND. RAND returns the reduction-AND of A in bit 0, with all other bits 0.
REQ-016 SHALL treat Op 111 as reserved: Result is 0 and Illegal is 1. All other ops give Illegal 0.
REQ-017 SHALL compute the result combinationally before stage 1. Stages 2..STAGES SHALL carry Result/Illegal unchanged.
REQ-018 SHALL transfer an input only when InValid and InReady are both 1, and an output only when OutValid and OutReady are both 1.
REQ-019 SHALL let a stage load when it is empty or its contents move forward in the same cycle. InReady SHALL equal the load condition of stage 1.
REQ-020 SHALL have a latency of exactly STAGES cycles from input handshake to OutValid when there is no backpressure, and a throughput of one op per cycle.
REQ-021 SHALL hold Result, Illegal and OutValid stable while OutValid=1 and OutReady=0.
REQ-022 SHALL let a full pipeline accept a new input in the same cycle the output handshake completes.
REQ-023 SHALL make Flush clear every stage valid bit on the next edge. An input presented during a Flush cycle SHALL be dropped, and InReady SHALL be 0 during Flush.
REQ-024 SHALL not change datapath registers when a stage is not loading. Data registers SHALL not be cleared by Flush.

Reset
REQ-025 SHALL clear every stage valid bit when Reset is sampled high. After that, OutValid=0, Result=0, Illegal=0 and InReady=0.
REQ-026 SHALL raise InReady in the first cycle after Reset is deasserted.
REQ-027 SHALL give Reset priority over Flush and over any handshake. Asserting Reset mid-operation discards all in-flight ops.

Configuration
REQ-028 SHALL use macro LOGIC_PIPE_ZERO_FLAG_EN. When it is defined, the unit SHALL add output Zero (1 bit), equal to 1 when the stage-1 result is all zeros. Zero SHALL be carried with Result, held under stall, and reset to 0.
REQ-029 SHALL have no Zero port and no related logic when LOGIC_PIPE_ZERO_FLAG_EN is undefined. All other behaviour SHALL be identical in both builds.

Structure
REQ-030 SHALL place the Op encodings (OP_AND..OP_RSVD), the op width constant (3) and the default WIDTH in shared package logic_pipe_pkg.
REQ-031 SHALL implement each stage as instances of sub-module logic_pipe_stage. Each instance holds the valid, data, Illegal and optional Zero bits with ready/valid logic, and the instances are chained STAGES times by a generate loop.

Verification (WIDTH=32, STAGES=2)
REQ-032 SHALL cover: A=0xF0F000FF, B=0x0FF00F0F, Op=AND/OR/XOR in back-to-back cycles with OutReady=1 -> Results 0x00F0000F, 0xFFF00FFF, 0xFF000FF0, each arriving 2 cycles after its input.
REQ-033 SHALL cover: Op=111 with any operands -> Result 0x00000000 and Illegal=1. Op=110 with A=0xFFFFFFFF -> Result 0x00000001. Op=110 with A=0xFFFFFFFE -> Result 0x00000000.
REQ-034 SHALL cover: fill the pipe, then hold OutReady=0 for 5 cycles -> InReady=0 after 2 accepts, and the output stays stable. Release OutReady -> results are delivered in order with none lost or duplicated.
REQ-035 SHALL cover: Flush with 2 ops in flight and InValid=1 -> OutValid=0 on the next cycle, and none of the 3 ops is ever output.
REQ-036 SHALL cover: Reset asserted mid-stream -> OutValid=0, Result=0, InReady=0 after the edge, and InReady=1 one cycle after Reset falls.
REQ-037 SHALL cover, with LOGIC_PIPE_ZERO_FLAG_EN defined: AND of A=0xAAAAAAAA and B=0x55555555 -> Zero=1. OR of the same operands -> Zero=0.
